uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single usb_uart transmit stream (uart_in_data/valid/ready) between NUM_REQ
//   byte-stream requesters, e.g. the loopback FIFO, a status reporter and a debug dumper.
//   Round-robin arbitration at packet granularity: a grant is held until the requester's
//   'last' byte or MAX_PKT bytes, so packets never interleave. An optional header byte
//   tags each packet with its source. Sits between the requesters and usb_uart in top.
// PARAMETERS
//   NUM_REQ    4      number of requesters, 2..8
//   MAX_PKT    64     max data bytes per grant (header excluded) before forced release
//   HEADER_EN  1      1: emit header byte (HDR_BASE + grant index) before each packet
//   HDR_BASE   8'hF0  header base value; the sum wraps modulo 256
// PORTS
//   clk_48mhz  in   1          system clock; all logic on rising edge
//   reset_n    in   1          asynchronous, active-low reset
//   req_data   in   8*NUM_REQ  requester i byte on [8i+7:8i]
//   req_valid  in   NUM_REQ    requester i has a byte
//   req_last   in   NUM_REQ    requester i byte is the last of its packet (qualified by valid)
//   req_ready  out  NUM_REQ    requester i byte is accepted this cycle (valid & ready)
//   out_data   out  8          to uart_in_data
//   out_valid  out  1          to uart_in_valid
//   out_ready  in   1          from uart_in_ready
//   grant_id   out  3          index of the current or most recent grant
//   busy       out  1          a grant is active (state HDR or DATA)
//   ovl_err    out  1          sticky: a packet was cut at MAX_PKT without last
//   err_clr    in   1          clears ovl_err
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE, out_valid=0, out_data=0, req_ready=0,
//     grant_id=0, busy=0, ovl_err=0, rr pointer=0, byte count=0. A packet in flight is dropped.
//   Output stage: a single register. out_data/out_valid stay stable while out_valid & !out_ready.
//     slot_free = !out_valid | out_ready. When a transfer completes and nothing is loaded in
//     the same cycle, out_valid clears on the next edge.
//   FSM:
//     IDLE: if any req_valid, grant the first index i at or after ptr (cyclic) with req_valid;
//       register grant_id=i, count=0, busy=1; go to HDR if HEADER_EN, else DATA. No byte moves in IDLE.
//     HDR: when slot_free, load out_data=HDR_BASE+grant_id and out_valid=1; go to DATA.
//     DATA: req_ready[g] = req_valid[g] & slot_free (combinational). All other req_ready bits are 0.
//       On acceptance, load the byte and increment count. If req_last[g], or count reaches
//       MAX_PKT, go to IDLE, set ptr=(g+1) mod NUM_REQ and busy=0.
//       If the release is caused by the count reaching MAX_PKT without last, set ovl_err.
//       If req_valid[g] drops mid-packet, keep the grant and wait (no timeout).
//   Latency: a byte accepted at edge t is on out_data from t+1. The minimum gap between
//     packets is one IDLE cycle, plus one cycle for the header when HEADER_EN=1.
//   The count is a $clog2(MAX_PKT+1)-bit counter and never wraps.
//     A single-byte packet (last on the first byte) is legal.
//   ovl_err: if a set event and err_clr occur in the same cycle, the set wins.
//   Requests arriving during a grant wait. Fairness: every valid requester is served
//     within NUM_REQ-1 grants.
// TESTING
//   1. Reset with req_valid=4'b1111 held -> all outputs 0; after release, first grant is 0,
//      out_data=8'hF0, then req0's bytes.
//   2. All four requesters each send the 3-byte packet {i,i+1,i+1 last}, out_ready=1 ->
//      output F0 00 01 01 F1 01 02 02 F2 .. F3 ..; grant order 0,1,2,3; no interleaving.
//   3. Random out_ready stalls (50%) during the test 2 stream -> identical byte sequence;
//      out_data never changes while out_valid & !out_ready.
//   4. Requester 2 sends 70 bytes with no last, MAX_PKT=64 -> 64 bytes forwarded, then
//      ovl_err=1 and the grant moves to 3. A pulse on err_clr clears the flag.
//   5. HEADER_EN=0, only req1 active, 1-byte packets back-to-back -> one byte every 2 cycles;
//      grant_id stays 1.
//   6. Assert reset_n low in the middle of a DATA packet -> out_valid=0 immediately;
//      after release the FSM is IDLE with ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one UART transmit byte stream
// between NUM_REQ requesters, with an optional per-packet source header byte.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_PKT   = 64,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [7:0]  HDR_BASE  = 8'hF0
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 ovl_err,
    input  logic                 err_clr
);
    localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);
    localparam int unsigned GID_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [GID_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             slot_free;
    logic [CNT_W-1:0] cnt_inc;
    logic             found_hi, found_lo;
    logic [GID_W-1:0] pick_hi, pick_lo, pick;
    logic             g_valid, g_last;
    logic [7:0]       g_data;

    assign slot_free = !out_valid_q || out_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Cyclic priority search: first valid index at or after ptr, else first valid overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !found_hi && (GID_W'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                pick_hi  = GID_W'(i);
            end
            if (req_valid[i] && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = GID_W'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    // Select the granted requester's byte stream.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        ovl_d       = ovl_q && !err_clr;
        req_ready   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = HEADER_EN ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                if (slot_free) begin
                    out_data_d  = HDR_BASE + 8'(grant_q);
                    out_valid_d = 1'b1;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == GID_W'(i)) begin
                        req_ready[i] = req_valid[i] && slot_free;
                    end
                end
                if (g_valid && slot_free) begin
                    out_data_d  = g_data;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_inc;
                    if (g_last || (cnt_inc == CNT_W'(MAX_PKT))) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        ptr_d   = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + GID_W'(1);
                        // A forced cut sets the sticky error even if err_clr is high.
                        if (!g_last) begin
                            ovl_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            ovl_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            ovl_q       <= ovl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign ovl_err   = ovl_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: header/packet ordering, stalls,
// MAX_PKT cut with sticky error, header-less throughput and mid-packet reset.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ = 4;

    logic clk_48mhz = 1'b0;
    logic reset_n   = 1'b0;
    always #10 clk_48mhz = ~clk_48mhz;

    // Main instance (header enabled)
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_last  = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2:0]        grant_id;
    logic              busy;
    logic              ovl_err;
    logic              err_clr   = 1'b0;

    // Header-less instance
    logic [8*NREQ-1:0] nh_data   = '0;
    logic [NREQ-1:0]   nh_valid  = '0;
    logic [NREQ-1:0]   nh_last   = '0;
    logic [NREQ-1:0]   nh_ready;
    logic [7:0]        nh_out_data;
    logic              nh_out_valid;
    logic              nh_out_ready = 1'b1;
    logic [2:0]        nh_grant;
    logic              nh_busy;
    logic              nh_ovl;
    logic              nh_err_clr   = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT(64), .HEADER_EN(1'b1), .HDR_BASE(8'hF0)) u_dut (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .ovl_err(ovl_err), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT(64), .HEADER_EN(1'b0), .HDR_BASE(8'hF0)) u_dut_nh (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n),
        .req_data(nh_data), .req_valid(nh_valid), .req_last(nh_last), .req_ready(nh_ready),
        .out_data(nh_out_data), .out_valid(nh_out_valid), .out_ready(nh_out_ready),
        .grant_id(nh_grant), .busy(nh_busy), .ovl_err(nh_ovl), .err_clr(nh_err_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0]      src_q [NREQ][$];
    logic [7:0]      obs[$];
    logic [7:0]      exp_q[$];
    logic [NREQ-1:0] acc;
    logic            fire;
    logic            stall = 1'b0;
    logic            held  = 1'b0;
    logic [7:0]      held_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        else n_pass++;
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic wait_obs(input int n, input int budget);
        int c = 0;
        while (obs.size() < n && c < budget) begin
            @(posedge clk_48mhz);
            c++;
        end
    endtask

    task automatic compare_stream(input string tag);
        logic [31:0] got;
        check({tag, "_len"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < obs.size()) ? 32'(obs[k]) : 32'hFFFF_FFFF;
            check($sformatf("%s[%0d]", tag, k), got, 32'(exp_q[k]));
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
    endtask

    // Requester model + output monitor: sample at negedge, update just after posedge.
    initial begin : drive
        forever begin
            @(negedge clk_48mhz);
            acc  = req_valid & req_ready;
            fire = out_valid & out_ready;
            if (held) check("hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held_data});
            held      = out_valid & !out_ready;
            held_data = out_data;
            if (fire) obs.push_back(out_data);
            @(posedge clk_48mhz);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_last[i]        = src_q[i][0][8];
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int fires;
        int consec;
        logic prev_fire;
        logic [7:0] exp_b;

        // Reset held with all requesters valid
        for (int i = 0; i < NREQ; i++) begin
            push_byte(i, 8'(i), 1'b0);
            push_byte(i, 8'(i + 1), 1'b0);
            push_byte(i, 8'(i + 1), 1'b1);
        end
        repeat (3) @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        check("rst_valid_in", 32'(req_valid), 32'hF);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovl", 32'(ovl_err), 32'd0);
        @(posedge clk_48mhz);
        #3 reset_n = 1'b1;

        // Four 3-byte packets, no stalls
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            exp_q.push_back(8'hF0 + 8'(i));
            exp_q.push_back(8'(i));
            exp_q.push_back(8'(i + 1));
            exp_q.push_back(8'(i + 1));
        end
        wait_obs(16, 400);
        compare_stream("rr");

        // Same stream under random output stalls
        @(posedge clk_48mhz);
        #3;
        obs.delete();
        stall = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            push_byte(i, 8'(i), 1'b0);
            push_byte(i, 8'(i + 1), 1'b0);
            push_byte(i, 8'(i + 1), 1'b1);
        end
        wait_obs(16, 2000);
        compare_stream("stall");
        stall = 1'b0;
        repeat (3) @(posedge clk_48mhz);

        // Overlong packet on req2 cut at 64 bytes, req3 waiting
        @(negedge clk_48mhz);
        check("ovl_pre", 32'(ovl_err), 32'd0);
        @(posedge clk_48mhz);
        #3;
        obs.delete();
        for (int k = 0; k < 70; k++) push_byte(2, 8'h10 + 8'(k), 1'b0);
        push_byte(3, 8'hA0, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'hF2);
        for (int k = 0; k < 64; k++) exp_q.push_back(8'h10 + 8'(k));
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hF2);
        for (int k = 64; k < 70; k++) exp_q.push_back(8'h10 + 8'(k));
        wait_obs(74, 1000);
        compare_stream("maxpkt");
        repeat (2) @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        check("ovl_set", 32'(ovl_err), 32'd1);
        check("ovl_busy", 32'(busy), 32'd1);
        check("ovl_grant", 32'(grant_id), 32'd2);
        @(posedge clk_48mhz);
        #3 err_clr = 1'b1;
        @(posedge clk_48mhz);
        #3 err_clr = 1'b0;
        @(negedge clk_48mhz);
        check("ovl_clr", 32'(ovl_err), 32'd0);
        @(posedge clk_48mhz);
        #3 reset_n = 1'b0;
        clear_sources();
        held = 1'b0;
        repeat (2) @(posedge clk_48mhz);
        #3 reset_n = 1'b1;
        obs.delete();

        // Mid-packet reset after a completed req1 grant (ptr would be 2)
        push_byte(1, 8'h55, 1'b0);
        push_byte(1, 8'h56, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'hF1);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h56);
        wait_obs(3, 200);
        compare_stream("pre_rst");
        @(posedge clk_48mhz);
        #3;
        for (int k = 0; k < 10; k++) push_byte(1, 8'h60 + 8'(k), k == 9);
        wait_obs(5, 200);
        @(posedge clk_48mhz);
        #3;
        check("mid_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        clear_sources();
        held = 1'b0;
        obs.delete();
        repeat (2) @(posedge clk_48mhz);
        #3 reset_n = 1'b1;
        @(negedge clk_48mhz);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_grant", 32'(grant_id), 32'd0);
        obs.delete();
        @(posedge clk_48mhz);
        #3;
        push_byte(0, 8'h30, 1'b1);
        push_byte(3, 8'h33, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'h33);
        wait_obs(4, 200);
        compare_stream("ptr0");

        // Header-less instance: req1 single-byte packets back to back
        @(posedge clk_48mhz);
        #1;
        nh_valid = 4'b0010;
        nh_last  = 4'b0010;
        nh_data  = '0;
        fires = 0;
        consec = 0;
        prev_fire = 1'b0;
        exp_b = 8'h00;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk_48mhz);
            if (nh_out_valid) begin
                check("nh_byte", 32'(nh_out_data), 32'(exp_b));
                exp_b = exp_b + 8'd1;
            end
            if (nh_ready[1]) begin
                fires++;
                if (prev_fire) consec++;
            end
            prev_fire = nh_ready[1];
            @(posedge clk_48mhz);
            #1;
            if (prev_fire) nh_data[15:8] = nh_data[15:8] + 8'd1;
        end
        @(negedge clk_48mhz);
        check("nh_fires", 32'(fires), 32'd5);
        check("nh_consec", 32'(consec), 32'd0);
        check("nh_grant", 32'(nh_grant), 32'd1);
        check("nh_bytes_seen", 32'(exp_b), 32'd4);
        nh_valid = '0;
        nh_last  = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
